// File: rtl/modular_addsub_pipe.sv
// modular_addsub_pipe: multi-lane modular add/subtract, two register stages.
// S1 holds the raw (DATA_WIDTH+1)-bit sum/difference per lane; S2 holds the
// corrected residue. Valid/ready handshake on both sides with bubble collapse.
module modular_addsub_pipe #(
    parameter int DATA_WIDTH = 14,
    parameter int MODULUS    = 12289,
    parameter int LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            mode,
    input  logic [LANES*DATA_WIDTH-1:0] x_in,
    input  logic [LANES*DATA_WIDTH-1:0] y_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] z_out,
    output logic                        range_err,
    input  logic                        err_clear,
    output logic [15:0]                 op_count
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MOD_W = W'(MODULUS);
    localparam logic [W:0]   MOD_X = (W+1)'(MODULUS);

    // Subtraction fix-up: a set borrow bit means the difference wrapped, add M back.
    function automatic logic [W-1:0] fix_sub(input logic [W:0] raw);
        logic [W:0] t;
        t = raw[W] ? ({1'b0, raw[W-1:0]} + MOD_X) : {1'b0, raw[W-1:0]};
        return t[W-1:0];
    endfunction

    // Addition fix-up: one conditional subtraction of M.
    function automatic logic [W-1:0] fix_add(input logic [W:0] raw);
        logic [W:0] t;
        t = (raw >= MOD_X) ? (raw - MOD_X) : raw;
        return t[W-1:0];
    endfunction

    logic                    vld_p1_q;
    logic [LANES-1:0]        mode_p1_q;
    logic [LANES-1:0][W:0]   raw_p1_q;
    logic [LANES-1:0][W:0]   raw_p1_d;
    logic                    oor_p0;
    logic [W-1:0]            xl;
    logic [W-1:0]            yl;

    logic                    vld_p2_q;
    logic [LANES*W-1:0]      z_p2_q;
    logic [LANES*W-1:0]      z_p2_d;

    logic                    range_err_q;
    logic                    range_err_d;
    logic [15:0]             op_count_q;
    logic                    adv_p2;
    logic                    in_fire;
    logic                    out_fire;

    // S2 may load whenever it is empty or its content leaves this cycle;
    // S1 may load whenever S2 advances or S1 itself is empty.
    assign adv_p2    = !vld_p2_q || out_ready;
    assign in_ready  = rst || adv_p2 || !vld_p1_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = vld_p2_q && out_ready;

    assign out_valid = vld_p2_q;
    assign z_out     = z_p2_q;
    assign range_err = range_err_q;
    assign op_count  = op_count_q;

    // ---- stage 0 -> 1: raw per-lane sum/difference and operand range check
    always_comb begin
        raw_p1_d = '0;
        oor_p0   = 1'b0;
        xl       = '0;
        yl       = '0;
        for (int i = 0; i < LANES; i++) begin
            xl = x_in[i*W +: W];
            yl = y_in[i*W +: W];
            if (mode[i]) begin
                raw_p1_d[i] = {1'b0, xl} + {1'b0, yl};
            end else begin
                raw_p1_d[i] = {1'b0, xl} - {1'b0, yl};
            end
            if ((xl >= MOD_W) || (yl >= MOD_W)) begin
                oor_p0 = 1'b1;
            end
        end
    end

    // S1 valid bit: refilled from the input whenever S1 is allowed to move.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (in_ready) begin
            vld_p1_q <= in_valid;
        end
    end

    // S1 data: captured only on an accepted input, otherwise held.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            raw_p1_q  <= raw_p1_d;
            mode_p1_q <= mode;
        end
    end

    // ---- stage 1 -> 2: modular correction per lane
    always_comb begin
        z_p2_d = '0;
        for (int i = 0; i < LANES; i++) begin
            z_p2_d[i*W +: W] = mode_p1_q[i] ? fix_add(raw_p1_q[i]) : fix_sub(raw_p1_q[i]);
        end
    end

    // S2 valid bit: takes S1's valid whenever S2 advances, so bubbles collapse.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
        end else if (adv_p2) begin
            vld_p2_q <= vld_p1_q;
        end
    end

    // S2 result: loaded only with a real op so z_out stays put across stalls and bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_p2_q <= '0;
        end else if (adv_p2 && vld_p1_q) begin
            z_p2_q <= z_p2_d;
        end
    end

    // Sticky range error: a new error on an accepted input beats a clear.
    always_comb begin
        range_err_d = (range_err_q && !err_clear) || (in_fire && oor_p0);
    end

    // Range-error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    // Completed output transfers, free-running 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= 16'd0;
        end else if (out_fire) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Scoreboard bench for modular_addsub_pipe (DATA_WIDTH=14, M=12289, LANES=2).
module tb_modular_addsub_pipe;

    localparam int W = 14;
    localparam int M = 12289;
    localparam int L = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [L-1:0]     mode;
    logic [L*W-1:0]   x_in;
    logic [L*W-1:0]   y_in;
    logic             out_valid;
    logic             out_ready;
    logic [L*W-1:0]   z_out;
    logic             range_err;
    logic             err_clear;
    logic [15:0]      op_count;

    int checks;
    int errors;
    int cyc;
    int n_out;
    int base;
    bit lat_chk;
    bit rand_rdy;

    logic [L*W-1:0] exp_q[$];
    int             tin_q[$];

    modular_addsub_pipe #(
        .DATA_WIDTH(W),
        .MODULUS   (M),
        .LANES     (L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .x_in     (x_in),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z_out    (z_out),
        .range_err(range_err),
        .err_clear(err_clear),
        .op_count (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [L*W-1:0] pk(input int l1, input int l0);
        return {14'(l1), 14'(l0)};
    endfunction

    // Reference residues computed with plain integer arithmetic.
    function automatic logic [L*W-1:0] ref_z(input logic [L-1:0] m,
                                             input logic [L*W-1:0] x,
                                             input logic [L*W-1:0] y);
        logic [L*W-1:0] r;
        int a;
        int b;
        int v;
        r = '0;
        for (int i = 0; i < L; i++) begin
            a = int'(x[i*W +: W]);
            b = int'(y[i*W +: W]);
            v = m[i] ? ((a + b) % M) : ((a - b + M) % M);
            r[i*W +: W] = W'(v);
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Present one op; push its expected result once the handshake is seen.
    // Entered and left at posedge+1.
    task automatic send(input logic [L-1:0] m, input logic [L*W-1:0] x,
                        input logic [L*W-1:0] y, input logic [L*W-1:0] e);
        bit accepted;
        int k;
        accepted = 1'b0;
        k = 0;
        mode = m;
        x_in = x;
        y_in = y;
        in_valid = 1'b1;
        while (!accepted && k < 1000) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                tin_q.push_back(cyc);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [L-1:0]   rm;
        logic [L*W-1:0] rx;
        logic [L*W-1:0] ry;
        logic [L*W-1:0] zs;
        int             vcount;

        checks = 0;
        errors = 0;
        cyc = 0;
        n_out = 0;
        lat_chk = 1'b0;
        rand_rdy = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        mode = '0;
        x_in = '0;
        y_in = '0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                logic [L*W-1:0] e;
                int t;
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%0d required=none", z_out);
                    end else begin
                        e = exp_q.pop_front();
                        t = tin_q.pop_front();
                        chk("z_out", 32'(z_out), 32'(e));
                        if (lat_chk) chk("latency", 32'(cyc - t), 32'd2);
                    end
                    n_out++;
                end
            end
        join_none

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = n_out;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_z_out", 32'(z_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // subtraction with borrow, and zero
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(2'b00, pk(0, 5), pk(0, 10), pk(0, 12284));
        drain();
        chk("op_count_1", 32'(op_count), 32'd1);

        // addition hitting exactly M and exceeding M
        send(2'b11, pk(12000, 12288), pk(1000, 1), pk(711, 0));
        drain();
        chk("op_count_2", 32'(op_count), 32'd2);
        lat_chk = 1'b0;

        // backpressure: fill both stages, stall, then release
        out_ready = 1'b0;
        send(2'b01, pk(100, 1), pk(1, 2), pk(99, 3));
        send(2'b10, pk(6144, 0), pk(6145, 1), pk(0, 12288));
        mode = 2'b11;
        x_in = pk(12288, 12288);
        y_in = pk(12288, 12288);
        in_valid = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_head", 32'(z_out), 32'(pk(99, 3)));
        zs = z_out;
        repeat (2) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("stall_z_stable", 32'(z_out), 32'(zs));
            chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b11, pk(12288, 12288), pk(12288, 12288), pk(12287, 12287));
        drain();
        chk("op_count_5", 32'(op_count), 32'd5);

        // out-of-range operand, sticky flag, clear, set-wins
        chk("range_err_before", 32'(range_err), 32'd0);
        send(2'b00, pk(0, 12289), pk(0, 0), pk(0, 12289));
        chk("range_err_set", 32'(range_err), 32'd1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("range_err_cleared", 32'(range_err), 32'd0);
        err_clear = 1'b1;
        send(2'b10, pk(0, 0), pk(16383, 0), pk(4094, 0));
        err_clear = 1'b0;
        chk("range_err_set_wins", 32'(range_err), 32'd1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("range_err_cleared2", 32'(range_err), 32'd0);
        drain();
        chk("op_count_7", 32'(op_count), 32'd7);

        // reset with two ops in flight
        out_ready = 1'b0;
        send(2'b11, pk(1, 1), pk(1, 1), pk(2, 2));
        send(2'b11, pk(2, 2), pk(2, 2), pk(4, 4));
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_rst_mid", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tin_q.delete();
        base = n_out;
        out_ready = 1'b1;
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) vcount++;
            @(posedge clk);
            #1;
        end
        chk("post_rst_out_valid", 32'(vcount), 32'd0);
        chk("post_rst_op_count", 32'(op_count), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // random in-range ops with random backpressure and bubbles
        rand_rdy = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) tick(1);
            rm = 2'($urandom_range(0, 3));
            for (int i = 0; i < L; i++) begin
                rx[i*W +: W] = 14'($urandom_range(0, M - 1));
                ry[i*W +: W] = 14'($urandom_range(0, M - 1));
            end
            send(rm, rx, ry, ref_z(rm, rx, ry));
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        chk("op_count_random", 32'(op_count), 32'(16'(n_out - base)));
        chk("range_err_random", 32'(range_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
